// File: rtl/gf2m_serial_mult.sv
//------------------------------------------------------------------------------
// Module      : gf2m_serial_mult
// Description : Bit-serial MSB-first GF(2^M) multiplier with valid/ready ports.
//               Optional multiply-accumulate (z = A*B ^ C) when the macro
//               GF2M_MULT_MAC_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gf2m_serial_mult #(
  parameter int            M    = 4,
  parameter logic [M-1:0]  POLY = 'h9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
`ifdef GF2M_MULT_MAC_EN
  input  logic [M-1:0] c,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] z,
  output logic         busy
);

  localparam int CW = $clog2(M);

  localparam logic [1:0]    c_st_idle  = 2'd0;
  localparam logic [1:0]    c_st_run   = 2'd1;
  localparam logic [1:0]    c_st_done  = 2'd2;
  localparam logic [CW-1:0] c_cnt_load = CW'(M - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [M-1:0]  r_a;
  logic [M-1:0]  r_b;
  logic [M-1:0]  r_acc;
  logic [M-1:0]  r_z;
  logic [CW-1:0] r_cnt;
  logic [M-1:0]  w_shift;
  logic [M-1:0]  w_step;
  logic [M-1:0]  w_res;
  logic          w_last;

  // Multiply-by-x with reduction, then conditionally add A for this bit of B.
  assign w_shift = {r_acc[M-2:0], 1'b0} ^ (r_acc[M-1] ? POLY : '0);
  assign w_step  = w_shift ^ (r_b[r_cnt] ? r_a : '0);
  assign w_last  = (r_cnt == '0);

`ifdef GF2M_MULT_MAC_EN
  logic [M-1:0] r_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c <= '0;
    end else if (r_state == c_st_idle && in_valid) begin
      r_c <= c;
    end
  end

  assign w_res = w_step ^ r_c;
`else
  assign w_res = w_step;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (in_valid)  w_state_nxt = c_st_run;
      c_st_run:  if (w_last)    w_state_nxt = c_st_done;
      c_st_done: if (out_ready) w_state_nxt = c_st_idle;
      default:                  w_state_nxt = c_st_idle;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (r_state == c_st_idle);
    busy      = (r_state == c_st_run);
    out_valid = (r_state == c_st_done);
    z         = r_z;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_z   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_cnt <= c_cnt_load;
          end
        end
        c_st_run: begin
          r_acc <= w_step;
          // Count stops at zero rather than wrapping past the final step.
          if (!w_last) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_z <= w_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
